// File: rtl/bumpy_move.sv
// bumpy_move: frame-rate fixed-point motion integrator for the Bumpy object.
// Turns the Bumpy FSM state code into a registered top-left pixel position.
module bumpy_move #(
    parameter int INITIAL_X              = 280,
    parameter int INITIAL_Y              = 185,
    parameter int X_SPEED                = 128,
    parameter int JUMP_SPEED             = 640,
    parameter int GRAVITY                = 16,
    parameter int MAX_FALL_SPEED         = 512,
    parameter int FIXED_POINT_MULTIPLIER = 64,
    parameter int TILE_SIZE              = 32,
    parameter int OBJECT_WIDTH           = 32,
    parameter int SCREEN_WIDTH           = 640
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [3:0]         state,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY
);

    localparam int FP_SH = $clog2(FIXED_POINT_MULTIPLIER);

    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_IDLE  = 4'd1;
    localparam logic [3:0] S_LEFT  = 4'd2;
    localparam logic [3:0] S_RIGHT = 4'd3;
    localparam logic [3:0] S_DOWN  = 4'd4;
    localparam logic [3:0] S_UP    = 4'd5;
    localparam logic [3:0] S_DIE   = 4'd6;

    localparam logic signed [31:0] K_M         = FIXED_POINT_MULTIPLIER;
    localparam logic signed [31:0] K_INIT_X    = INITIAL_X * FIXED_POINT_MULTIPLIER;
    localparam logic signed [31:0] K_INIT_Y    = INITIAL_Y * FIXED_POINT_MULTIPLIER;
    localparam logic signed [31:0] K_X_SPEED   = X_SPEED;
    localparam logic signed [31:0] K_JUMP      = JUMP_SPEED;
    localparam logic signed [31:0] K_GRAVITY   = GRAVITY;
    localparam logic signed [31:0] K_MAX_FALL  = MAX_FALL_SPEED;
    localparam logic signed [31:0] K_TILE      = TILE_SIZE;
    localparam logic signed [31:0] K_HALF_TILE = TILE_SIZE / 2;
    localparam logic signed [31:0] K_TILE_MASK = ~(K_TILE - 32'sd1);
    localparam logic signed [31:0] K_X_MAX     = SCREEN_WIDTH - OBJECT_WIDTH;
    localparam logic signed [31:0] K_X_MAX_FP  = K_X_MAX * K_M;

    logic signed [31:0] xfp;
    logic signed [31:0] yfp;
    logic signed [31:0] yspeed;
    logic [3:0]         prev_state;
    logic               jump_pending;
    logic               snap_pending;

    logic signed [31:0] xfp_n;
    logic signed [31:0] yfp_n;
    logic signed [31:0] yspeed_n;
    logic               jump_n;
    logic               snap_n;
    logic               jump_take;
    logic               snap_take;

    logic signed [31:0] x_raw;
    logic signed [31:0] x_pix;
    logic signed [31:0] x_clamped;
    logic signed [31:0] y_fall;
    logic signed [31:0] ysp_inc;
    logic signed [31:0] ysp_fall;
    logic signed [31:0] y_round;
    logic signed [31:0] y_snap;

    // Shared datapath terms used by several state actions
    always_comb begin
        y_fall   = yfp + yspeed;
        ysp_inc  = yspeed + K_GRAVITY;
        ysp_fall = (ysp_inc > K_MAX_FALL) ? K_MAX_FALL : ysp_inc;
        y_round  = (yfp >>> FP_SH) + K_HALF_TILE;
        y_snap   = (y_round & K_TILE_MASK) <<< FP_SH;
    end

    always_comb begin
        x_raw = xfp;
        if (state == S_LEFT) begin
            x_raw = xfp - K_X_SPEED;
        end else if (state == S_RIGHT) begin
            x_raw = xfp + K_X_SPEED;
        end
        x_pix     = x_raw >>> FP_SH;
        x_clamped = x_raw;
        if (x_pix < 32'sd0) begin
            x_clamped = 32'sd0;
        end else if (x_pix > K_X_MAX) begin
            x_clamped = K_X_MAX_FP;
        end
    end

    always_comb begin
        xfp_n     = xfp;
        yfp_n     = yfp;
        yspeed_n  = yspeed;
        jump_take = 1'b0;
        snap_take = 1'b0;
        if (startOfFrame) begin
            case (state)
                S_RESET: begin
                    xfp_n    = K_INIT_X;
                    yfp_n    = K_INIT_Y;
                    yspeed_n = 32'sd0;
                end
                S_IDLE: begin
                    yspeed_n = 32'sd0;
                    if (snap_pending) begin
                        yfp_n     = y_snap;
                        snap_take = 1'b1;
                    end
                end
                S_LEFT, S_RIGHT: begin
                    xfp_n    = x_clamped;
                    yfp_n    = y_fall;
                    yspeed_n = ysp_fall;
                end
                S_UP: begin
                    if (jump_pending) begin
                        yfp_n     = yfp - K_JUMP;
                        yspeed_n  = K_GRAVITY - K_JUMP;
                        jump_take = 1'b1;
                    end else begin
                        yfp_n    = y_fall;
                        yspeed_n = ysp_fall;
                    end
                end
                S_DIE: begin
                    xfp_n = xfp;
                end
                default: begin
                    yfp_n    = y_fall;
                    yspeed_n = ysp_fall;
                end
            endcase
        end
    end

    // Entry flags arm on the first clk in a state and drop on exit or use
    always_comb begin
        jump_n = jump_pending;
        if (state != S_UP) begin
            jump_n = 1'b0;
        end else if (prev_state != S_UP) begin
            jump_n = 1'b1;
        end else if (jump_take) begin
            jump_n = 1'b0;
        end

        snap_n = snap_pending;
        if (state != S_IDLE) begin
            snap_n = 1'b0;
        end else if (prev_state != S_IDLE) begin
            snap_n = 1'b1;
        end else if (snap_take) begin
            snap_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            xfp          <= K_INIT_X;
            yfp          <= K_INIT_Y;
            yspeed       <= 32'sd0;
            prev_state   <= S_RESET;
            jump_pending <= 1'b0;
            snap_pending <= 1'b0;
        end else begin
            xfp          <= xfp_n;
            yfp          <= yfp_n;
            yspeed       <= yspeed_n;
            prev_state   <= state;
            jump_pending <= jump_n;
            snap_pending <= snap_n;
        end
    end

    assign topLeftX = 11'(xfp >>> FP_SH);
    assign topLeftY = 11'(yfp >>> FP_SH);

endmodule
